// File: rtl/cmp_result_tracker_if.sv
// ---------------------------------------------------------------------------
// cmp_result_tracker_if
// Purpose : Groups the sample bus from the 8-bit magnitude comparator into
//           the result tracker.
// Signals : in_valid - sample strobe; a/b/eq/gt/lt are valid this cycle
//           a, b     - operands applied to the comparator
//           eq/gt/lt - comparator outcome flags
// Modports: master drives the bus (comparator side or bench),
//           slave receives it (tracker side).
// ---------------------------------------------------------------------------
interface cmp_result_tracker_if;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       eq;
  logic       gt;
  logic       lt;

  modport master (output in_valid, a, b, eq, gt, lt);
  modport slave  (input  in_valid, a, b, eq, gt, lt);
endinterface

// File: rtl/cmp_result_tracker.sv
// ---------------------------------------------------------------------------
// cmp_result_tracker
// Purpose : Registers each valid comparator result and cross-checks it
//           against an internal unsigned compare of a and b. It also keeps
//           saturating per-outcome counters and tracks the current and the
//           longest run of identical good outcomes.
// Ports   : clk        - rising-edge clock
//           rst        - synchronous active-high reset (overrides everything)
//           i_smp      - sample bus (slave modport of cmp_result_tracker_if)
//           clear      - synchronous statistics clear
//           out_valid  - registered result valid pulse
//           res_kind   - registered outcome: 00 none, 01 GT, 10 LT, 11 EQ
//           err        - sample was not one-hot or disagreed with a vs b
//           gt/lt/eq/err_count - saturating outcome counters (CW bits)
//           run_len    - length of the current run of identical outcomes
//           max_run    - longest run since reset/clear
// ---------------------------------------------------------------------------
module cmp_result_tracker #(
  parameter int CW = 8,
  parameter int RW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_result_tracker_if.slave  i_smp,
  input  logic                 clear,
  output logic                 out_valid,
  output logic [1:0]           res_kind,
  output logic                 err,
  output logic [CW-1:0]        gt_count,
  output logic [CW-1:0]        lt_count,
  output logic [CW-1:0]        eq_count,
  output logic [CW-1:0]        err_count,
  output logic [RW-1:0]        run_len,
  output logic [RW-1:0]        max_run
);

  // State encoding equals the res_kind code of the outcome being run,
  // so a good sample's kind maps straight onto its RUN_ state.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN_GT = 2'b01,
    RUN_LT = 2'b10,
    RUN_EQ = 2'b11
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);

  state_t        r_state;
  logic          r_outValid;
  logic [1:0]    r_resKind;
  logic          r_err;
  logic [CW-1:0] r_gtCount, r_ltCount, r_eqCount, r_errCount;
  logic [RW-1:0] r_runLen, r_maxRun;

  logic          w_oneHot;
  logic [1:0]    w_kind;
  logic [1:0]    w_refKind;
  logic          w_sampleErr;
  logic          w_good;
  logic          w_badSample;
  state_t        w_baseState;
  state_t        w_nextState;
  logic [RW-1:0] w_baseRun, w_baseMax, w_nextRun, w_nextMax;
  logic [CW-1:0] w_nextGt, w_nextLt, w_nextEq, w_nextErr;

  function automatic logic [CW-1:0] satIncCnt(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [RW-1:0] satIncRun(input logic [RW-1:0] v);
    return (v == '1) ? v : v + RUN_ONE;
  endfunction

  // Classify the incoming sample: decode the comparator flags into a kind,
  // derive the reference kind from an unsigned a/b compare, and call the
  // sample an error if the flags are not one-hot or the two kinds differ.
  always_comb begin
    w_oneHot = ({i_smp.gt, i_smp.lt, i_smp.eq} == 3'b100) ||
               ({i_smp.gt, i_smp.lt, i_smp.eq} == 3'b010) ||
               ({i_smp.gt, i_smp.lt, i_smp.eq} == 3'b001);
    w_kind = 2'b00;
    if (i_smp.gt)      w_kind = 2'b01;
    else if (i_smp.lt) w_kind = 2'b10;
    else if (i_smp.eq) w_kind = 2'b11;
    if (i_smp.a > i_smp.b)      w_refKind = 2'b01;
    else if (i_smp.a < i_smp.b) w_refKind = 2'b10;
    else                        w_refKind = 2'b11;
    w_sampleErr = !w_oneHot || (w_kind != w_refKind);
    w_good      = i_smp.in_valid && !w_sampleErr;
    w_badSample = i_smp.in_valid && w_sampleErr;
  end

  // Next-state logic. Clear is applied first (back to IDLE), then a good
  // sample moves to the run state of its kind; error samples and idle
  // cycles leave the state alone.
  always_comb begin
    w_baseState = clear ? IDLE : r_state;
    w_nextState = w_baseState;
    if (w_good) w_nextState = state_t'(w_kind);
  end

  // Statistics next-values. Everything starts from the post-clear view so a
  // sample arriving in a clear cycle lands on zeroed statistics. max_run is
  // compared against the new run length so it never lags run_len.
  always_comb begin
    w_baseRun = clear ? '0 : r_runLen;
    w_baseMax = clear ? '0 : r_maxRun;
    w_nextGt  = clear ? '0 : r_gtCount;
    w_nextLt  = clear ? '0 : r_ltCount;
    w_nextEq  = clear ? '0 : r_eqCount;
    w_nextErr = clear ? '0 : r_errCount;
    w_nextRun = w_baseRun;
    if (w_good) begin
      if (w_baseState == state_t'(w_kind)) w_nextRun = satIncRun(w_baseRun);
      else                                 w_nextRun = RUN_ONE;
      case (w_kind)
        2'b01:   w_nextGt = satIncCnt(w_nextGt);
        2'b10:   w_nextLt = satIncCnt(w_nextLt);
        default: w_nextEq = satIncCnt(w_nextEq);
      endcase
    end
    if (w_badSample) w_nextErr = satIncCnt(w_nextErr);
    w_nextMax = (w_nextRun > w_baseMax) ? w_nextRun : w_baseMax;
  end

  // State and result registers. Reset wins over clear and any sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
      r_resKind  <= 2'b00;
      r_err      <= 1'b0;
      r_gtCount  <= '0;
      r_ltCount  <= '0;
      r_eqCount  <= '0;
      r_errCount <= '0;
      r_runLen   <= '0;
      r_maxRun   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_outValid <= i_smp.in_valid;
      r_resKind  <= w_good ? w_kind : 2'b00;
      r_err      <= w_badSample;
      r_gtCount  <= w_nextGt;
      r_ltCount  <= w_nextLt;
      r_eqCount  <= w_nextEq;
      r_errCount <= w_nextErr;
      r_runLen   <= w_nextRun;
      r_maxRun   <= w_nextMax;
    end
  end

  assign out_valid = r_outValid;
  assign res_kind  = r_resKind;
  assign err       = r_err;
  assign gt_count  = r_gtCount;
  assign lt_count  = r_ltCount;
  assign eq_count  = r_eqCount;
  assign err_count = r_errCount;
  assign run_len   = r_runLen;
  assign max_run   = r_maxRun;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// ---------------------------------------------------------------------------
// tb_cmp_result_tracker
// Purpose : Directed self-checking bench for cmp_result_tracker. A narrow
//           instance (CW=4, RW=3) exercises saturation; a default-width
//           instance on the same sample bus shows the same history unwrapped.
// ---------------------------------------------------------------------------
module tb_cmp_result_tracker;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  cmp_result_tracker_if sampleBus ();

  logic       sOutValid, sErr;
  logic [1:0] sResKind;
  logic [3:0] sGt, sLt, sEq, sErrCnt;
  logic [2:0] sRun, sMax;

  logic       wOutValid, wErr;
  logic [1:0] wResKind;
  logic [7:0] wGt, wLt, wEq, wErrCnt;
  logic [5:0] wRun, wMax;

  int assertCount = 0;
  int failCount   = 0;

  cmp_result_tracker #(.CW(4), .RW(3)) dutSmall (
    .clk(clk), .rst(rst), .i_smp(sampleBus.slave), .clear(clear),
    .out_valid(sOutValid), .res_kind(sResKind), .err(sErr),
    .gt_count(sGt), .lt_count(sLt), .eq_count(sEq), .err_count(sErrCnt),
    .run_len(sRun), .max_run(sMax)
  );

  cmp_result_tracker dutWide (
    .clk(clk), .rst(rst), .i_smp(sampleBus.slave), .clear(clear),
    .out_valid(wOutValid), .res_kind(wResKind), .err(wErr),
    .gt_count(wGt), .lt_count(wLt), .eq_count(wEq), .err_count(wErrCnt),
    .run_len(wRun), .max_run(wMax)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, then return 1 unit after
  // the following rising edge so the registered results can be sampled.
  task automatic applyStimulus(input logic rstIn, input logic clrIn,
                               input logic valid, input logic [7:0] aIn,
                               input logic [7:0] bIn, input logic gtIn,
                               input logic ltIn, input logic eqIn);
    @(negedge clk);
    rst                = rstIn;
    clear              = clrIn;
    sampleBus.in_valid = valid;
    sampleBus.a        = aIn;
    sampleBus.b        = bIn;
    sampleBus.gt       = gtIn;
    sampleBus.lt       = ltIn;
    sampleBus.eq       = eqIn;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed,
                             input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Check the full output set of the narrow instance.
  task automatic checkSmall(input string tag, input int ov, input int rk,
                            input int er, input int gt, input int lt,
                            input int eq, input int ec, input int run,
                            input int mx);
    checkOutput({tag, "_outValid"}, int'(sOutValid), ov);
    checkOutput({tag, "_resKind"},  int'(sResKind),  rk);
    checkOutput({tag, "_err"},      int'(sErr),      er);
    checkOutput({tag, "_gtCount"},  int'(sGt),       gt);
    checkOutput({tag, "_ltCount"},  int'(sLt),       lt);
    checkOutput({tag, "_eqCount"},  int'(sEq),       eq);
    checkOutput({tag, "_errCount"}, int'(sErrCnt),   ec);
    checkOutput({tag, "_runLen"},   int'(sRun),      run);
    checkOutput({tag, "_maxRun"},   int'(sMax),      mx);
  endtask

  // Check the counters and run registers of the default-width instance.
  task automatic checkWide(input string tag, input int gt, input int lt,
                           input int eq, input int ec, input int run,
                           input int mx);
    checkOutput({tag, "_wGtCount"},  int'(wGt),     gt);
    checkOutput({tag, "_wLtCount"},  int'(wLt),     lt);
    checkOutput({tag, "_wEqCount"},  int'(wEq),     eq);
    checkOutput({tag, "_wErrCount"}, int'(wErrCnt), ec);
    checkOutput({tag, "_wRunLen"},   int'(wRun),    run);
    checkOutput({tag, "_wMaxRun"},   int'(wMax),    mx);
  endtask

  // Directed scenario with hand-computed expectations.
  initial begin
    rst = 1'b1;
    clear = 1'b0;
    sampleBus.in_valid = 1'b0;
    sampleBus.a = 8'h00;
    sampleBus.b = 8'h00;
    sampleBus.gt = 1'b0;
    sampleBus.lt = 1'b0;
    sampleBus.eq = 1'b0;

    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    checkSmall("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 1, 8'h35, 8'h12, 1, 0, 0);
    checkSmall("gt1", 1, 1, 0, 1, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 8'h35, 8'h12, 1, 0, 0);
    applyStimulus(0, 0, 1, 8'h35, 8'h12, 1, 0, 0);
    checkSmall("gt3", 1, 1, 0, 3, 0, 0, 0, 3, 3);

    applyStimulus(0, 0, 0, 8'h35, 8'h12, 1, 0, 0);
    checkSmall("idle", 0, 0, 0, 3, 0, 0, 0, 3, 3);

    applyStimulus(0, 0, 1, 8'h80, 8'h7F, 0, 1, 0);
    checkSmall("errWrong", 1, 0, 1, 3, 0, 0, 1, 3, 3);
    applyStimulus(0, 0, 1, 8'h80, 8'h7F, 1, 0, 1);
    checkSmall("errTwoHot", 1, 0, 1, 3, 0, 0, 2, 3, 3);
    applyStimulus(0, 0, 1, 8'h80, 8'h7F, 0, 0, 0);
    checkSmall("errNone", 1, 0, 1, 3, 0, 0, 3, 3, 3);

    applyStimulus(0, 0, 1, 8'h80, 8'h7F, 1, 0, 0);
    checkSmall("gtExtend", 1, 1, 0, 4, 0, 0, 3, 4, 4);

    applyStimulus(0, 0, 1, 8'h12, 8'h35, 0, 1, 0);
    checkSmall("lt", 1, 2, 0, 4, 1, 0, 3, 1, 4);
    applyStimulus(0, 0, 1, 8'hA7, 8'hA7, 0, 0, 1);
    checkSmall("eq", 1, 3, 0, 4, 1, 1, 3, 1, 4);

    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 8'h00, 8'h00, 0, 0, 1);
    checkSmall("eqSat", 1, 3, 0, 4, 1, 15, 3, 7, 7);
    checkWide("eqSat", 4, 1, 21, 3, 21, 21);

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    checkSmall("clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkWide("clear", 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 1, 8'h35, 8'h12, 1, 0, 0);
    checkSmall("clearGt", 1, 1, 0, 1, 0, 0, 0, 1, 1);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 8'h35, 8'h12, 1, 0, 0);
    checkSmall("run5", 1, 1, 0, 5, 0, 0, 0, 5, 5);

    applyStimulus(1, 0, 1, 8'h35, 8'h12, 1, 0, 0);
    checkSmall("rstMid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkWide("rstMid", 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 1, 8'h35, 8'h12, 1, 0, 0);
    checkSmall("gtAfterRst", 1, 1, 0, 1, 0, 0, 0, 1, 1);

    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    checkOutput("finalIdle_outValid", int'(sOutValid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
